rr_output_alloc: RTL

//  Per-output allocator for the 4x4 dropping-flow-control router; one instance per output port.

---
 rtl/rr_output_alloc_if.sv | 30 +++
 rtl/rr_output_alloc.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rr_output_alloc_if.sv
// Purpose: bundles the header taps of the four input registers and the allocator's outputs.
// Latency: none; this is wiring only.
// Backpressure: none; flow control is dropping, so losing or illegal heads are flagged on drop.
// Ports: hdr0..hdr3 carry phit[17:14] of input registers 0..3, where [3:2] is the type and [1:0] the destination.
//        sel is the one-hot 4:1 mux select, shift strips the route field and drop marks discarded heads.
//        busy, timeout and err report the lock state, an idle-timeout release and a protocol error.
interface rr_output_alloc_if;
    logic [3:0] hdr0;
    logic [3:0] hdr1;
    logic [3:0] hdr2;
    logic [3:0] hdr3;
    logic [3:0] sel;
    logic       shift;
    logic [3:0] drop;
    logic       busy;
    logic       timeout;
    logic       err;

    // The master drives the phit headers and observes the allocation.
    modport master (
        output hdr0, hdr1, hdr2, hdr3,
        input  sel, shift, drop, busy, timeout, err
    );

    // The slave is the allocator itself.
    modport slave (
        input  hdr0, hdr1, hdr2, hdr3,
        output sel, shift, drop, busy, timeout, err
    );
endinterface

// File: rtl/rr_output_alloc.sv
// Purpose: round-robin allocator for one router output; it locks the output to a packet from its head to its tail.
// Latency: the grant appears in the same cycle as the head, and the output is released the cycle after the tail.
// Backpressure: none; heads that lose arbitration, or that arrive while the output is locked, are flagged on drop.
// Ports: clk and rst are the clock and the synchronous active-high reset; bus is the slave modport.
//        On bus, hdr0..hdr3 are inputs; sel, shift and drop are combinational outputs.
//        busy is registered; timeout and err are 1-cycle pulses.
module rr_output_alloc #(
    parameter logic [1:0] PORT_ID = 2'd0,
    parameter int         TIMEOUT = 15,
    parameter int         CW      = 4
) (
    input  logic               clk,
    input  logic               rst,
    rr_output_alloc_if.slave   bus
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} st_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    st_t           st_q, st_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [3:0] hdr [4];
    logic [3:0] cand;
    logic [1:0] win;
    logic       win_vld;
    logic [1:0] scan_idx;
    logic [3:0] own_oh;
    logic [1:0] own_typ;
    logic [3:0] sel_c;
    logic [3:0] drop_c;
    logic       shift_c;
    logic       tmo_c;
    logic       err_c;

    assign hdr[0] = bus.hdr0;
    assign hdr[1] = bus.hdr1;
    assign hdr[2] = bus.hdr2;
    assign hdr[3] = bus.hdr3;

    // A candidate is a head phit whose destination is this output.
    always_comb begin
        cand = '0;
        for (int i = 0; i < 4; i++) begin
            cand[i] = (hdr[i][3:2] == 2'b01) && (hdr[i][1:0] == PORT_ID);
        end
    end

    // Scan downward from the farthest offset, so the candidate nearest rr_ptr is written last and wins.
    always_comb begin
        win      = '0;
        win_vld  = 1'b0;
        scan_idx = '0;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = rr_ptr_q + 2'(k);
            if (cand[scan_idx]) begin
                win     = scan_idx;
                win_vld = 1'b1;
            end
        end
    end

    assign own_oh  = 4'b0001 << owner_q;
    assign own_typ = hdr[owner_q][3:2];

    always_comb begin
        st_d     = st_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        sel_c    = '0;
        drop_c   = '0;
        shift_c  = 1'b0;
        tmo_c    = 1'b0;
        err_c    = 1'b0;
        case (st_q)
            IDLE: begin
                // Only heads matter here; body and tail phits are ignored.
                if (win_vld) begin
                    sel_c    = 4'b0001 << win;
                    shift_c  = 1'b1;
                    drop_c   = cand & ~(4'b0001 << win);
                    st_d     = BUSY;
                    owner_d  = win;
                    rr_ptr_d = win + 2'd1;
                    cnt_d    = '0;
                end
            end
            BUSY: begin
                sel_c  = own_oh;
                drop_c = cand & ~own_oh;
                case (own_typ)
                    2'b10: cnt_d = '0;
                    2'b11: begin
                        // The tail is forwarded now, and competing heads this cycle are still dropped.
                        st_d  = IDLE;
                        cnt_d = '0;
                    end
                    2'b00: begin
                        if (cnt_q == CNT_LAST) begin
                            tmo_c = 1'b1;
                            st_d  = IDLE;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        // A head from the owner while locked is illegal: abort the packet and drop that head.
                        err_c  = 1'b1;
                        sel_c  = '0;
                        drop_c = cand;
                        st_d   = IDLE;
                        cnt_d  = '0;
                    end
                endcase
            end
            default: st_d = IDLE;
        endcase
    end

    assign bus.sel     = rst ? 4'b0000 : sel_c;
    assign bus.drop    = rst ? 4'b0000 : drop_c;
    assign bus.shift   = shift_c & ~rst;
    assign bus.timeout = tmo_c & ~rst;
    assign bus.err     = err_c & ~rst;
    assign bus.busy    = (st_q == BUSY) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            st_q     <= st_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
